// File: rtl/fpga_send_if.sv
// Bus bundle between the fabric/Pi side and the fpga_send transmitter.
interface fpga_send_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       send;
    logic [7:0] gpio_out;
    logic       gpio_strobe;
    logic       pi_ack;
    logic       busy;
    logic [5:0] LED;

    // Fabric and Pi side: drives payload, send request and acknowledge
    modport master (
        output in_data, in_valid, send, pi_ack,
        input  in_ready, gpio_out, gpio_strobe, busy, LED
    );

    // Transmitter side
    modport slave (
        input  in_data, in_valid, send, pi_ack,
        output in_ready, gpio_out, gpio_strobe, busy, LED
    );
endinterface

// File: rtl/fpga_send.sv
// FPGA-to-Pi byte transmitter: FIFO-buffered payload sent as a framed burst
// (sync, length, payload, checksum) paced by a strobe/ack handshake.
module fpga_send #(
    parameter int unsigned DEPTH     = 16,     // power of two, 2..128
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        pi_clk,
    input  logic        rst,
    fpga_send_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
        S_DATA,
        S_CSUM
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [AW-1:0] r_rd_ptr, w_rd_ptr_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [CW-1:0] r_len, w_len_nxt;
    logic [CW-1:0] r_rem, w_rem_nxt;
    logic [7:0]    r_csum, w_csum_nxt;
    logic [7:0]    r_gpio_out, w_gpio_out_nxt;
    logic          r_strobe, w_strobe_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_in_ready, w_in_ready_nxt;
    logic [5:0]    r_led, w_led_nxt;

    logic          w_wr_en;
    logic          w_xfer;
    logic          w_pop;
    logic [7:0]    w_head;

    assign w_wr_en = bus.in_valid && r_in_ready;
    assign w_xfer  = r_strobe && bus.pi_ack;
    assign w_head  = r_mem[r_rd_ptr];

    // FIFO storage; contents are don't-care once pointers are reset
    always_ff @(posedge pi_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    // State and registered outputs
    always_ff @(posedge pi_clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_len      <= '0;
            r_rem      <= '0;
            r_csum     <= '0;
            r_gpio_out <= '0;
            r_strobe   <= 1'b0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
            r_led      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_len      <= w_len_nxt;
            r_rem      <= w_rem_nxt;
            r_csum     <= w_csum_nxt;
            r_gpio_out <= w_gpio_out_nxt;
            r_strobe   <= w_strobe_nxt;
            r_busy     <= w_busy_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_led      <= w_led_nxt;
        end
    end

    // Next-state, FIFO bookkeeping and next output values
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_count_nxt    = r_count;
        w_len_nxt      = r_len;
        w_rem_nxt      = r_rem;
        w_csum_nxt     = r_csum;
        w_gpio_out_nxt = r_gpio_out;
        w_strobe_nxt   = r_strobe;
        w_busy_nxt     = r_busy;
        w_led_nxt      = r_led;
        w_pop          = 1'b0;

        if (w_wr_en) begin
            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (bus.send) begin
                    // a byte written on the same edge belongs to this frame
                    w_state_nxt    = S_SYNC;
                    w_len_nxt      = r_count + CW'(w_wr_en);
                    w_gpio_out_nxt = SYNC_BYTE;
                    w_strobe_nxt   = 1'b1;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_SYNC: begin
                if (w_xfer) begin
                    w_state_nxt    = S_LEN;
                    w_gpio_out_nxt = 8'(r_len);
                    w_csum_nxt     = 8'(r_len);
                end
            end
            S_LEN: begin
                if (w_xfer) begin
                    if (r_len != '0) begin
                        w_state_nxt    = S_DATA;
                        w_gpio_out_nxt = w_head;
                        w_csum_nxt     = r_csum + w_head;
                        w_rem_nxt      = r_len - CW'(1);
                        w_pop          = 1'b1;
                    end else begin
                        w_state_nxt    = S_CSUM;
                        w_gpio_out_nxt = r_csum;
                    end
                end
            end
            S_DATA: begin
                // r_rem counts payload bytes still to present after this one
                if (w_xfer) begin
                    if (r_rem != '0) begin
                        w_gpio_out_nxt = w_head;
                        w_csum_nxt     = r_csum + w_head;
                        w_rem_nxt      = r_rem - CW'(1);
                        w_pop          = 1'b1;
                    end else begin
                        w_state_nxt    = S_CSUM;
                        w_gpio_out_nxt = r_csum;
                    end
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    w_state_nxt  = S_IDLE;
                    w_strobe_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_strobe_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
            end
        endcase

        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + AW'(1);
        end

        w_count_nxt = r_count + CW'(w_wr_en) - CW'(w_pop);

        if (w_xfer) begin
            w_led_nxt = r_gpio_out[5:0];
        end

        w_in_ready_nxt = (w_state_nxt == S_IDLE) && (w_count_nxt < CW'(DEPTH));
    end

    assign bus.gpio_out    = r_gpio_out;
    assign bus.gpio_strobe = r_strobe;
    assign bus.busy        = r_busy;
    assign bus.in_ready    = r_in_ready;
    assign bus.LED         = r_led;

endmodule

// File: tb/tb_fpga_send.sv
// Directed self-checking bench for fpga_send.
module tb_fpga_send;
    logic pi_clk;
    logic rst;
    int   checks;
    int   errors;

    fpga_send_if bus ();

    fpga_send #(.DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
        .pi_clk (pi_clk),
        .rst    (rst),
        .bus    (bus)
    );

    initial pi_clk = 1'b0;
    always #5 pi_clk = ~pi_clk;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required end of test");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic       ack;
        logic [7:0] exp_out;
        logic       exp_strobe;
        logic       exp_busy;
        logic       exp_in_ready;
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] fq [$];

    task automatic step();
        @(posedge pi_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_send();
        bus.send = 1'b1;
        step();
        bus.send = 1'b0;
    endtask

    // Checks the frame held in fq with pi_ack held high, then the return to idle
    task automatic expect_frame(input string name);
        bus.pi_ack = 1'b1;
        for (int i = 0; i < fq.size(); i++) begin
            chk($sformatf("%s byte%0d", name, i), {23'd0, bus.gpio_strobe, bus.gpio_out},
                {23'd0, 1'b1, fq[i]});
            step();
        end
        bus.pi_ack = 1'b0;
        chk({name, " strobe_end"}, 32'(bus.gpio_strobe), 32'd0);
        chk({name, " busy_end"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.send     = 1'b0;
        bus.pi_ack   = 1'b0;

        // Stall frame: A5,04,1C, E0 held 4 cycles, 91,AA,3B
        vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h1C, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'hE0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'hE0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'hE0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 8'hE0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 8'h91, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 8'h3B, 1'b1, 1'b1, 1'b0};

        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst gpio_out", 32'(bus.gpio_out), 32'd0);
        chk("rst strobe", 32'(bus.gpio_strobe), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst led", 32'(bus.LED), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);

        // Basic frame
        push(8'h1C); push(8'hE0); push(8'h91); push(8'hAA);
        pulse_send();
        fq = '{8'hA5, 8'h04, 8'h1C, 8'hE0, 8'h91, 8'hAA, 8'h3B};
        expect_frame("basic");
        chk("basic led", 32'(bus.LED), 32'h3B);
        chk("basic in_ready", 32'(bus.in_ready), 32'd1);

        // Ack stall, table-driven
        push(8'h1C); push(8'hE0); push(8'h91); push(8'hAA);
        pulse_send();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall[%0d] out", i), 32'(bus.gpio_out), 32'(vecs[i].exp_out));
            chk($sformatf("stall[%0d] strobe", i), 32'(bus.gpio_strobe), 32'(vecs[i].exp_strobe));
            chk($sformatf("stall[%0d] busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
            chk($sformatf("stall[%0d] in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_in_ready));
            bus.pi_ack = vecs[i].ack;
            step();
        end
        bus.pi_ack = 1'b0;
        chk("stall strobe_end", 32'(bus.gpio_strobe), 32'd0);
        chk("stall busy_end", 32'(bus.busy), 32'd0);
        chk("stall led", 32'(bus.LED), 32'h3B);

        // Empty FIFO send
        pulse_send();
        fq = '{8'hA5, 8'h00, 8'h00};
        expect_frame("empty");

        // Fill past full: 17th byte dropped
        for (int i = 1; i <= 17; i++) begin
            push(8'(i));
            if (i == 15) chk("full in_ready@15", 32'(bus.in_ready), 32'd1);
            if (i == 16) chk("full in_ready@16", 32'(bus.in_ready), 32'd0);
        end
        pulse_send();
        fq.delete();
        fq.push_back(8'hA5);
        fq.push_back(8'h10);
        for (int i = 1; i <= 16; i++) fq.push_back(8'(i));
        fq.push_back(8'h98);
        expect_frame("full");

        // Same-cycle send and write
        push(8'h05);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h07;
        bus.send     = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.send     = 1'b0;
        fq = '{8'hA5, 8'h02, 8'h05, 8'h07, 8'h0E};
        expect_frame("samecyc");

        // Busy guards: send and in_valid mid-frame are ignored
        push(8'h11); push(8'h22);
        pulse_send();
        chk("guard sync", 32'(bus.gpio_out), 32'hA5);
        chk("guard in_ready", 32'(bus.in_ready), 32'd0);
        bus.pi_ack   = 1'b1;
        bus.send     = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        step();
        chk("guard len", 32'(bus.gpio_out), 32'h02);
        chk("guard in_ready mid", 32'(bus.in_ready), 32'd0);
        step();
        chk("guard d0", 32'(bus.gpio_out), 32'h11);
        bus.send     = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("guard d1", 32'(bus.gpio_out), 32'h22);
        step();
        chk("guard csum", 32'(bus.gpio_out), 32'h35);
        step();
        bus.pi_ack = 1'b0;
        chk("guard strobe_end", 32'(bus.gpio_strobe), 32'd0);
        chk("guard busy_end", 32'(bus.busy), 32'd0);
        pulse_send();
        fq = '{8'hA5, 8'h00, 8'h00};
        expect_frame("guard empty");

        // Reset during DATA
        push(8'h01); push(8'h02); push(8'h03);
        pulse_send();
        bus.pi_ack = 1'b1;
        step();
        step();
        chk("rstmid in data", 32'(bus.gpio_out), 32'h01);
        bus.pi_ack = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid strobe", 32'(bus.gpio_strobe), 32'd0);
        chk("rstmid busy", 32'(bus.busy), 32'd0);
        chk("rstmid led", 32'(bus.LED), 32'd0);
        chk("rstmid in_ready", 32'(bus.in_ready), 32'd1);
        pulse_send();
        fq = '{8'hA5, 8'h00, 8'h00};
        expect_frame("rstmid empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
